mult4b_seq: RTL

MULT4B_SEQ -- requirements
Module: mult4b_seq

---
 rtl/mult4b_pkg.sv | 17 +
 rtl/sum4b.sv | 14 +
 rtl/mult4b_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mult4b_pkg.sv
// Shared constants and FSM state encoding for the 4-bit shift-and-add multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult4b_pkg;

    localparam int WIDTH = 4;                 // operand width, fixed by the sum4b adder
    localparam int ITER  = 4;                 // one ADD/SHIFT pair per multiplier bit
    localparam int CNT_W = $clog2(ITER);      // iteration counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sum4b.sv
// Purpose: 4-bit unsigned combinational adder with carry-out.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
// Ports: xi, yi - addends; zi - 4-bit sum; co - carry out.
module sum4b (
    input  logic [3:0] xi,
    input  logic [3:0] yi,
    output logic       co,
    output logic [3:0] zi
);

    assign {co, zi} = {1'b0, xi} + {1'b0, yi};

endmodule

// File: rtl/mult4b_seq.sv
// Purpose: sequential 4x4 unsigned multiplier (shift-and-add) built around one sum4b adder.
// Latency: start accepted at edge 0 -> done pulse in the cycle after edge 9.
// Backpressure: start is ignored while busy, in DONE, and during the done-pulse cycle.
// Ports: clk/rst_n - clock and async active-low reset; start/a/b - request and operands;
//        busy - ADD/SHIFT in progress; done - one-cycle completion pulse; product - held result.
module mult4b_seq #(
    parameter int WIDTH = mult4b_pkg::WIDTH   // only 4 is supported (sum4b is 4 bits wide)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    import mult4b_pkg::*;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;            // multiplicand
    logic [WIDTH-1:0]     l_q, l_d;            // multiplier, becomes product low half
    logic [WIDTH-1:0]     h_q, h_d;            // partial-product high half
    logic                 c_q, c_d;            // carry out of the last add
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic                 sum_co;
    logic [WIDTH-1:0]     sum_z;

    // The only adder on the datapath: accumulates M into the high half.
    sum4b u_sum4b (
        .xi (h_q),
        .yi (m_q),
        .co (sum_co),
        .zi (sum_z)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        l_d       = l_q;
        h_d       = h_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // done_q marks the tail of the previous operation; a start seen
                // in that cycle is dropped so completion spans DONE plus the pulse.
                if (start && !done_q) begin
                    m_d     = a;
                    l_d     = b;
                    h_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (l_q[0]) begin
                    {c_d, h_d} = {sum_co, sum_z};
                end else begin
                    c_d = 1'b0;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                // {C,H,L} >> 1: carry enters H[3], H[0] enters L[3].
                {c_d, h_d, l_d} = {1'b0, c_q, h_q, l_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = ADD;
                end
            end
            DONE: begin
                // Result and pulse are registered together so done and the
                // new product appear in the same cycle.
                product_d = {h_q, l_q};
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            l_q       <= '0;
            h_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            l_q       <= l_d;
            h_q       <= h_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == ADD) || (state_q == SHIFT);
    assign done    = done_q;
    assign product = product_q;

endmodule
